// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, drives a single-outstanding req/gnt/rvalid
// instruction port, buffers responses in a 2-entry FIFO and loads the IF/ID register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic [1:0]  pc_src,
    input  logic [31:0] jump_target,
    input  logic [31:0] jr_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc_plus4,
    output logic        if_valid
);

    logic [31:0] r_pc;
    logic [31:0] r_req_pc;
    logic        r_outst;
    logic        r_kill;
    logic [1:0]  r_occ;
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [31:0] r_fifo_instr [2];
    logic [31:0] r_fifo_pc4   [2];
    logic [31:0] r_if_instr;
    logic [31:0] r_if_pc_plus4;
    logic        r_if_valid;

    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_resp;
    logic        w_push;
    logic        w_pop;
    logic        w_grant;
    logic [2:0]  w_level;

    // pc_src only counts when the decoder's instruction is not being held
    assign w_redirect = branch_taken | (~stall & ((pc_src == 2'b01) | (pc_src == 2'b10)));

    always_comb begin
        w_target = jump_target;
        if (branch_taken) begin
            w_target = branch_target;
        end else if (pc_src == 2'b10) begin
            w_target = jr_target;
        end
        w_target[1:0] = 2'b00;
    end

    assign w_resp  = imem_rvalid & r_outst;
    assign w_push  = w_resp & ~r_kill & ~w_redirect;
    assign w_pop   = ~stall & ~w_redirect & (r_occ != 2'd0);

    // Entries that will be buffered after this cycle, counting the in-flight response
    assign w_level = {1'b0, r_occ} + {2'b00, r_outst} - {2'b00, w_pop};

    assign imem_req  = reset_n & ~w_redirect & (~r_outst | imem_rvalid) & (w_level < 3'd2);
    assign imem_addr = r_pc;
    assign w_grant   = imem_req & imem_gnt;

    assign if_instr    = r_if_instr;
    assign if_pc_plus4 = r_if_pc_plus4;
    assign if_valid    = r_if_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc     <= RESET_PC;
            r_req_pc <= RESET_PC;
            r_outst  <= 1'b0;
            r_kill   <= 1'b0;
        end else begin
            if (w_redirect) begin
                r_pc <= w_target;
            end else if (w_grant) begin
                r_pc <= r_pc + 32'd4;
            end
            if (w_grant) begin
                r_req_pc <= r_pc;
            end
            if (w_grant) begin
                r_outst <= 1'b1;
            end else if (w_resp) begin
                r_outst <= 1'b0;
            end
            // A response still in flight across a redirect belongs to the old path
            if (w_resp) begin
                r_kill <= 1'b0;
            end else if (w_redirect & r_outst) begin
                r_kill <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_occ    <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else if (w_redirect) begin
            r_occ    <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_instr[r_wr_ptr] <= imem_rdata;
            r_fifo_pc4[r_wr_ptr]   <= r_req_pc + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_if_instr    <= NOP_WORD;
            r_if_pc_plus4 <= 32'd0;
            r_if_valid    <= 1'b0;
        end else if (w_redirect || (!stall && !w_pop)) begin
            r_if_instr    <= NOP_WORD;
            r_if_pc_plus4 <= 32'd0;
            r_if_valid    <= 1'b0;
        end else if (w_pop) begin
            r_if_instr    <= r_fifo_instr[r_rd_ptr];
            r_if_pc_plus4 <= r_fifo_pc4[r_rd_ptr];
            r_if_valid    <= 1'b1;
        end
    end

endmodule
